// File: rtl/iob_ram_tdp_be_ctrl_pkg.sv
// iob_ram_tdp_be_ctrl_pkg: shared types for the TDP RAM controller.
// FSM state encodings and round-robin priority reset value.
package iob_ram_tdp_be_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Requester 0 owns the tie-break after reset.
  localparam logic PRIO_RST = 1'b0;

endpackage

// File: rtl/iob_ram_tdp_be_ctrl_rr.sv
// iob_ram_tdp_be_ctrl_rr: same-address conflict detect + round-robin grant.
// Ports: clk_i, arst_n_i, run_i, v0/v1 valid, a0/a1 addr, wr0/wr1 write,
//        g0_o/g1_o grants (drive the requester ready outputs).
module iob_ram_tdp_be_ctrl_rr
  import iob_ram_tdp_be_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              run_i,
  input  logic              v0_i,
  input  logic              v1_i,
  input  logic [ADDR_W-1:0] a0_i,
  input  logic [ADDR_W-1:0] a1_i,
  input  logic              wr0_i,
  input  logic              wr1_i,
  output logic              g0_o,
  output logic              g1_o
);

  logic prioQ;
  logic conflict;

  // Only a write to a shared address needs arbitration;
  // two reads of one address are served together.
  assign conflict = v0_i & v1_i & (a0_i == a1_i)
                  & (wr0_i | wr1_i);

  assign g0_o = run_i & v0_i & (~conflict | ~prioQ);
  assign g1_o = run_i & v1_i & (~conflict |  prioQ);

  // The loser of a conflict gets the next one.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prioQ <= PRIO_RST;
    end else if (run_i & conflict) begin
      prioQ <= ~prioQ;
    end
  end

endmodule

// File: rtl/iob_ram_tdp_be_ctrl.sv
// iob_ram_tdp_be_ctrl: maps two requesters onto an external TDP BE RAM.
// r0 -> port A, r1 -> port B; 1-cycle read latency; rr on write conflicts.
// Ports: clk_i, arst_n_i; rk_valid/addr/wdata/wstrb_i, rk_ready/rvalid/rdata_o;
//        enX_o, weX_o, addrX_o, dX_o, dX_i for X in {A,B}; init_done_o.
// Macro IOB_RAM_TDP_BE_CTRL_INIT_EN: zero-fill the RAM via port A after reset.
module iob_ram_tdp_be_ctrl
  import iob_ram_tdp_be_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                r0_valid_i,
  input  logic [ADDR_W-1:0]   r0_addr_i,
  input  logic [DATA_W-1:0]   r0_wdata_i,
  input  logic [DATA_W/8-1:0] r0_wstrb_i,
  output logic                r0_ready_o,
  output logic                r0_rvalid_o,
  output logic [DATA_W-1:0]   r0_rdata_o,
  input  logic                r1_valid_i,
  input  logic [ADDR_W-1:0]   r1_addr_i,
  input  logic [DATA_W-1:0]   r1_wdata_i,
  input  logic [DATA_W/8-1:0] r1_wstrb_i,
  output logic                r1_ready_o,
  output logic                r1_rvalid_o,
  output logic [DATA_W-1:0]   r1_rdata_o,
  output logic                enA_o,
  output logic [DATA_W/8-1:0] weA_o,
  output logic [ADDR_W-1:0]   addrA_o,
  output logic [DATA_W-1:0]   dA_o,
  input  logic [DATA_W-1:0]   dA_i,
  output logic                enB_o,
  output logic [DATA_W/8-1:0] weB_o,
  output logic [ADDR_W-1:0]   addrB_o,
  output logic [DATA_W-1:0]   dB_o,
  input  logic [DATA_W-1:0]   dB_i,
  output logic                init_done_o
);

  logic              inInit;
  logic              live;
  logic [ADDR_W-1:0] clrAddr;
  logic              rv0Q;
  logic              rv1Q;

`ifdef IOB_RAM_TDP_BE_CTRL_INIT_EN
  state_t            stateQ;
  state_t            stateD;
  logic [ADDR_W-1:0] cntQ;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      stateQ <= ST_INIT;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      if (stateQ == ST_INIT) begin
        cntQ <= cntQ + 1'b1;
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_INIT: if (&cntQ) stateD = ST_RUN;
      ST_RUN:  stateD = ST_RUN;
    endcase
  end

  // Reset gating keeps every output quiet while arst_n_i is low.
  assign inInit  = arst_n_i & (stateQ == ST_INIT);
  assign live    = arst_n_i & (stateQ == ST_RUN);
  assign clrAddr = cntQ;
`else
  assign inInit  = 1'b0;
  assign live    = arst_n_i;
  assign clrAddr = '0;
`endif

  assign init_done_o = live;

  iob_ram_tdp_be_ctrl_rr #(
    .ADDR_W (ADDR_W)
  ) uRr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .run_i    (live),
    .v0_i     (r0_valid_i),
    .v1_i     (r1_valid_i),
    .a0_i     (r0_addr_i),
    .a1_i     (r1_addr_i),
    .wr0_i    (|r0_wstrb_i),
    .wr1_i    (|r1_wstrb_i),
    .g0_o     (r0_ready_o),
    .g1_o     (r1_ready_o)
  );

  always_comb begin
    enA_o   = 1'b0;
    weA_o   = '0;
    addrA_o = '0;
    dA_o    = '0;
    if (inInit) begin
      enA_o   = 1'b1;
      weA_o   = '1;
      addrA_o = clrAddr;
    end else if (r0_ready_o) begin
      enA_o   = 1'b1;
      weA_o   = r0_wstrb_i;
      addrA_o = r0_addr_i;
      dA_o    = r0_wdata_i;
    end
  end

  always_comb begin
    enB_o   = 1'b0;
    weB_o   = '0;
    addrB_o = '0;
    dB_o    = '0;
    if (r1_ready_o) begin
      enB_o   = 1'b1;
      weB_o   = r1_wstrb_i;
      addrB_o = r1_addr_i;
      dB_o    = r1_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rv0Q <= 1'b0;
      rv1Q <= 1'b0;
    end else begin
      rv0Q <= r0_ready_o & ~(|r0_wstrb_i);
      rv1Q <= r1_ready_o & ~(|r1_wstrb_i);
    end
  end

  assign r0_rvalid_o = rv0Q;
  assign r1_rvalid_o = rv1Q;
  assign r0_rdata_o  = rv0Q ? dA_i : '0;
  assign r1_rdata_o  = rv1Q ? dB_i : '0;

endmodule

// File: tb/tb_iob_ram_tdp_be_ctrl.sv
// tb_iob_ram_tdp_be_ctrl: self-checking bench with an external RAM model.
// Table vectors, directed corners and random traffic vs a memory/turn model.
module tb_iob_ram_tdp_be_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk;
  logic          arst_n;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [3:0]    r0_wstrb, r1_wstrb;
  logic          r0_ready, r1_ready;
  logic          r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          enA, enB;
  logic [3:0]    weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dAo, dBo, dAi, dBi;
  logic          init_done;

  iob_ram_tdp_be_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .r0_valid_i(r0_valid), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_wstrb_i(r0_wstrb),
    .r0_ready_o(r0_ready), .r0_rvalid_o(r0_rvalid),
    .r0_rdata_o(r0_rdata),
    .r1_valid_i(r1_valid), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_wstrb_i(r1_wstrb),
    .r1_ready_o(r1_ready), .r1_rvalid_o(r1_rvalid),
    .r1_rdata_o(r1_rdata),
    .enA_o(enA), .weA_o(weA), .addrA_o(addrA),
    .dA_o(dAo), .dA_i(dAi),
    .enB_o(enB), .weB_o(weB), .addrB_o(addrB),
    .dB_o(dBo), .dB_i(dBi),
    .init_done_o(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM (environment, not the reference).
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (enA) begin
      for (int b = 0; b < 4; b++)
        if (weA[b]) ram[addrA][8*b +: 8] <= dAo[8*b +: 8];
      dAi <= ram[addrA];
    end
    if (enB) begin
      for (int b = 0; b < 4; b++)
        if (weB[b]) ram[addrB][8*b +: 8] <= dBo[8*b +: 8];
      dBi <= ram[addrB];
    end
  end

  int nTests = 0;
  int nFail  = 0;

  // Reference: word contents, whose turn on a conflict, pending reads.
  logic [DW-1:0] refMem [16];
  int            turn = 0;
  logic          pendRv0, pendRv1;
  logic [DW-1:0] pendRd0, pendRd1;

  typedef struct {
    logic v0; logic [3:0] a0; logic [3:0] s0; logic [31:0] d0;
    logic v1; logic [3:0] a1; logic [3:0] s1; logic [31:0] d1;
    logic e0; logic e1;
    logic ck0; logic [31:0] rd0;
    logic ck1; logic [31:0] rd1;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] d,
                                        logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  task automatic idle();
    r0_valid = 0; r0_addr = 0; r0_wdata = 0; r0_wstrb = 0;
    r1_valid = 0; r1_addr = 0; r1_wdata = 0; r1_wstrb = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic doCycle(input logic v0, input logic [3:0] a0,
                         input logic [3:0] s0, input logic [31:0] d0,
                         input logic v1, input logic [3:0] a1,
                         input logic [3:0] s1, input logic [31:0] d1,
                         output logic g0, output logic g1);
    logic conf, e0, e1;
    r0_valid = v0; r0_addr = a0; r0_wstrb = s0; r0_wdata = d0;
    r1_valid = v1; r1_addr = a1; r1_wstrb = s1; r1_wdata = d1;
    @(negedge clk);
    conf = v0 && v1 && (a0 == a1) && (s0 != 0 || s1 != 0);
    e0 = v0 && (!conf || turn == 0);
    e1 = v1 && (!conf || turn == 1);
    chk("ready0", r0_ready, e0);
    chk("ready1", r1_ready, e1);
    chk("enA", enA, e0);
    chk("enB", enB, e1);
    chk("weA", weA, e0 ? s0 : 4'h0);
    chk("weB", weB, e1 ? s1 : 4'h0);
    if (e0) begin
      chk("addrA", addrA, a0);
      chk("dA", dAo, d0);
    end
    if (e1) begin
      chk("addrB", addrB, a1);
      chk("dB", dBo, d1);
    end
    chk("rvalid0", r0_rvalid, pendRv0);
    chk("rvalid1", r1_rvalid, pendRv1);
    if (pendRv0) chk("rdata0", r0_rdata, pendRd0);
    if (pendRv1) chk("rdata1", r1_rdata, pendRd1);
    if (conf) turn = e0 ? 1 : 0;
    pendRv0 = e0 && s0 == 0;
    pendRv1 = e1 && s1 == 0;
    pendRd0 = refMem[a0];
    pendRd1 = refMem[a1];
    if (e0 && s0 != 0) refMem[a0] = merge(refMem[a0], d0, s0);
    if (e1 && s1 != 0) refMem[a1] = merge(refMem[a1], d1, s1);
    g0 = r0_ready;
    g1 = r1_ready;
    @(posedge clk); #1;
  endtask

  task automatic modelReset();
    turn = 0;
    pendRv0 = 0; pendRv1 = 0;
  endtask

`ifdef IOB_RAM_TDP_BE_CTRL_INIT_EN
  // Called at posedge+1 right after release; requests must be ignored.
  task automatic initSeq(input int upto);
    r0_valid = 1; r0_wstrb = 4'hF; r0_wdata = 32'h5A5A5A5A;
    r1_valid = 1; r1_wstrb = 4'h0;
    for (int n = 0; n < upto; n++) begin
      @(negedge clk);
      chk("initEnA", enA, 1'b1);
      chk("initWeA", weA, 4'hF);
      chk("initAddrA", addrA, n);
      chk("initDA", dAo, 0);
      chk("initEnB", enB, 1'b0);
      chk("initRdy0", r0_ready, 1'b0);
      chk("initRdy1", r1_ready, 1'b0);
      chk("initDone", init_done, 1'b0);
    end
    if (upto == 16) begin
      @(negedge clk);
      chk("initDoneRise", init_done, 1'b1);
    end
    @(posedge clk); #1;
    idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic g0, g1;
    logic v0, v1;
    logic [3:0] a0, a1, s0, s1;

    tbl[0]  = '{1'b1,4'd3,4'hF,32'hA0, 1'b1,4'd3,4'hF,32'hB0,
                1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[1]  = '{1'b1,4'd3,4'hF,32'hA1, 1'b1,4'd3,4'hF,32'hB1,
                1'b0,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[2]  = '{1'b1,4'd3,4'hF,32'hA2, 1'b1,4'd3,4'hF,32'hB2,
                1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[3]  = '{1'b1,4'd3,4'hF,32'hA3, 1'b1,4'd3,4'hF,32'hB3,
                1'b0,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[4]  = '{1'b1,4'd3,4'hF,32'hA4, 1'b1,4'd3,4'hF,32'hB4,
                1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[5]  = '{1'b1,4'd3,4'hF,32'hA5, 1'b1,4'd3,4'hF,32'hB5,
                1'b0,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[6]  = '{1'b1,4'd5,4'hF,32'h11, 1'b1,4'd5,4'h3,32'h22,
                1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[7]  = '{1'b0,4'd0,4'h0,32'h0,  1'b1,4'd5,4'h3,32'h22,
                1'b0,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[8]  = '{1'b1,4'd7,4'hF,32'h47, 1'b0,4'd0,4'h0,32'h0,
                1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[9]  = '{1'b1,4'd7,4'h0,32'h0,  1'b1,4'd7,4'h0,32'h0,
                1'b1,1'b1, 1'b1,32'h47, 1'b1,32'h47};
    tbl[10] = '{1'b1,4'd5,4'h0,32'h0,  1'b0,4'd0,4'h0,32'h0,
                1'b1,1'b0, 1'b1,32'h22, 1'b0,32'h0};
    tbl[11] = '{1'b1,4'd3,4'h0,32'h0,  1'b1,4'd5,4'h0,32'h0,
                1'b1,1'b1, 1'b1,32'hB5, 1'b1,32'h22};
    tbl[12] = '{1'b1,4'd2,4'h0,32'h0,  1'b1,4'd2,4'h1,32'hFF,
                1'b0,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[13] = '{1'b1,4'd2,4'h0,32'h0,  1'b0,4'd0,4'h0,32'h0,
                1'b1,1'b0, 1'b1,32'hFF, 1'b0,32'h0};
    tbl[14] = '{1'b1,4'd8,4'hF,32'h12345678,
                1'b1,4'd9,4'hC,32'hAABBCCDD,
                1'b1,1'b1, 1'b0,32'h0, 1'b0,32'h0};
    tbl[15] = '{1'b1,4'd8,4'h0,32'h0,  1'b1,4'd9,4'h0,32'h0,
                1'b1,1'b1, 1'b1,32'h12345678, 1'b1,32'hAABB0029};
    tbl[16] = '{1'b0,4'd0,4'h0,32'h0,  1'b0,4'd0,4'h0,32'h0,
                1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0};

    for (int i = 0; i < 16; i++) begin
      refMem[i] = '0;
`ifdef IOB_RAM_TDP_BE_CTRL_INIT_EN
      ram[i] = $urandom;
`else
      ram[i] = '0;
`endif
    end
    dAi = '0; dBi = '0;
    modelReset();

    // Reset with requests pending: everything must stay quiet.
    arst_n = 1'b0;
    r0_valid = 1; r0_addr = 1; r0_wstrb = 0; r0_wdata = 0;
    r1_valid = 1; r1_addr = 2; r1_wstrb = 4'hF; r1_wdata = 1;
    @(posedge clk); #1;
    chk("rstReady0", r0_ready, 1'b0);
    chk("rstReady1", r1_ready, 1'b0);
    chk("rstEnA", enA, 1'b0);
    chk("rstEnB", enB, 1'b0);
    chk("rstWeB", weB, 4'h0);
    chk("rstRvalid0", r0_rvalid, 1'b0);
    chk("rstRdata0", r0_rdata, 0);
    chk("rstDone", init_done, 1'b0);
    @(posedge clk); #1;
    idle();
    arst_n = 1'b1;

`ifdef IOB_RAM_TDP_BE_CTRL_INIT_EN
    // Interrupt clearing at cycle 8, then a full clear.
    initSeq(8);
    r0_valid = 1; r1_valid = 1;
    arst_n = 1'b0;
    #1;
    chk("midRstEnA", enA, 1'b0);
    chk("midRstWeA", weA, 4'h0);
    chk("midRstAddrA", addrA, 0);
    chk("midRstRdy0", r0_ready, 1'b0);
    @(posedge clk); #1;
    idle();
    arst_n = 1'b1;
    initSeq(16);
`else
    #1;
    chk("doneAtRelease", init_done, 1'b1);
    @(posedge clk); #1;
`endif

    // Every word starts at zero.
    for (int i = 0; i < 16; i++)
      doCycle(1, i[3:0], 0, 0, 1, 4'(15 - i), 0, 0, g0, g1);

    // Write/read sweep, r0 writes, r1 reads back.
    for (int i = 0; i < 16; i++) begin
      doCycle(1, i[3:0], 4'hF, 32'h20 + i, 0, 0, 0, 0, g0, g1);
      doCycle(0, 0, 0, 0, 1, i[3:0], 0, 0, g0, g1);
      chk("sweepRv", r1_rvalid, 1'b1);
      chk("sweepRd", r1_rdata, 32'h20 + i);
    end

    for (int i = 0; i < 17; i++) begin
      doCycle(tbl[i].v0, tbl[i].a0, tbl[i].s0, tbl[i].d0,
              tbl[i].v1, tbl[i].a1, tbl[i].s1, tbl[i].d1, g0, g1);
      chk($sformatf("tbl%0d_g0", i), g0, tbl[i].e0);
      chk($sformatf("tbl%0d_g1", i), g1, tbl[i].e1);
      if (tbl[i].ck0) begin
        chk($sformatf("tbl%0d_rv0", i), r0_rvalid, 1'b1);
        chk($sformatf("tbl%0d_rd0", i), r0_rdata, tbl[i].rd0);
      end
      if (tbl[i].ck1) begin
        chk($sformatf("tbl%0d_rv1", i), r1_rvalid, 1'b1);
        chk($sformatf("tbl%0d_rd1", i), r1_rdata, tbl[i].rd1);
      end
    end

    // Random traffic on a few addresses to provoke conflicts.
    for (int n = 0; n < 300; n++) begin
      v0 = ($urandom % 4) != 0;
      v1 = ($urandom % 4) != 0;
      a0 = 4'($urandom_range(0, 3));
      a1 = 4'($urandom_range(0, 3));
      s0 = ($urandom % 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      s1 = ($urandom % 2) ? 4'($urandom_range(1, 15)) : 4'h0;
      doCycle(v0, a0, s0, $urandom, v1, a1, s1, $urandom, g0, g1);
    end

    // Give priority to r1, then reset with a read in flight.
    if (turn == 0)
      doCycle(1, 4, 4'hF, 1, 1, 4, 4'hF, 2, g0, g1);
    r0_valid = 1; r0_addr = 1; r0_wstrb = 0;
    @(negedge clk);
    chk("preRstRdy0", r0_ready, 1'b1);
    #1;
    arst_n = 1'b0;
    #1;
    chk("rstInFlightRdy0", r0_ready, 1'b0);
    chk("rstInFlightEnA", enA, 1'b0);
    @(posedge clk); #1;
    chk("rstDropRvalid0", r0_rvalid, 1'b0);
    chk("rstDropRdata0", r0_rdata, 0);
    idle();
    arst_n = 1'b1;
    modelReset();
`ifdef IOB_RAM_TDP_BE_CTRL_INIT_EN
    for (int i = 0; i < 16; i++) refMem[i] = '0;
    initSeq(16);
`else
    #1;
    @(posedge clk); #1;
`endif
    doCycle(1, 6, 4'hF, 3, 1, 6, 4'hF, 4, g0, g1);
    chk("prioRst_g0", g0, 1'b1);
    chk("prioRst_g1", g1, 1'b0);
    doCycle(1, 6, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("postRstRd", r0_rdata, 32'h3);
    doCycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
